// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory responder.
//   - state_e : responder FSM states (idle, wait, response)
//   - op_e    : captured access type (load or store)
//   - CNT_W   : width of the latency wait counter
package mem_if_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } op_e;

  // A byte address is word-aligned when its two low bits are clear.
  function automatic logic is_misaligned(logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 synchronous memory array.
//   clk   : clock, rising edge
//   we    : write enable; wdata is written to mem[index] at the edge
//   index : word index for both read and write
//   wdata : write data
//   rdata : registered read data, mem[index] as seen before any same-edge write
// Contents are never reset.
module dmem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data-memory port. Services one load or
// store at a time with LATENCY wait cycles and stalls the pipeline meanwhile.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   MemRead  : load request (level, held while stall=1)
//   MemWrite : store request (level, held while stall=1); wins over MemRead
//   addr     : byte address; word index is addr[AW+1:2], upper bits ignored
//   wd       : store data
//   rd       : registered load data, updated only by load responses
//   stall    : pipeline hold, combinational
//   valid    : one-cycle response pulse
//   misalign : response flag for a captured address with addr[1:0] != 0
// LATENCY must lie in 1..15 to fit the wait counter.
module dmem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        valid,
  output logic        misalign
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rd_q, rd_d;

  logic              arr_we;
  logic [AW-1:0]     arr_index;
  logic [31:0]       arr_rdata;
  logic              cap_misaligned;

  // Address bits above the array span wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  assign cap_misaligned = is_misaligned(addr_q[1:0]);

  // In idle the array is read with the live address so that the registered
  // read data is already valid by the final wait cycle even when LATENCY=1.
  assign arr_index = (state_q == StIdle) ? addr[AW+1:2] : addr_q[AW+1:2];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    stall   = 1'b0;
    arr_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (MemRead || MemWrite) begin
          op_d    = MemWrite ? OpWr : OpRd;
          addr_d  = addr[AW+1:0];
          wd_d    = wd;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = StWait;
          stall   = 1'b1;
        end
      end
      StWait: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = StResp;
          // Both the array write and the rd update land on the edge into RESP.
          if (op_q == OpWr) begin
            arr_we = !cap_misaligned;
          end else begin
            rd_d = cap_misaligned ? 32'h0 : arr_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        // The held request belongs to the finished access; look again in idle.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Reset aborts the access: no stall and no pending store reaches the array.
    if (rst) begin
      stall  = 1'b0;
      arr_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpRd;
      addr_q  <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .index (arr_index),
    .wdata (wd_q),
    .rdata (arr_rdata)
  );

  assign rd       = rd_q;
  assign valid    = (state_q == StResp);
  assign misalign = valid && cap_misaligned;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipelined CPU's data-memory port: the other end of the MemRead/MemWrite/addr/wd/rd interface.
- Services one load or store at a time with a configurable access latency.
- Drives a stall back to the pipeline so the PC, IF_ID and downstream registers hold until the access completes.
- Replaces the zero-latency data memory when the pipeline is run against realistic memory timing.

Parameters:
- DEPTH, 256, number of 32-bit words in the backing array (power of two).
- LATENCY, 2, number of wait cycles between request acceptance and response (1..15).
- AW, 8, word-index width = log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- MemRead  input  1  load request, level, held by CPU while stall=1.
- MemWrite  input  1  store request, level, held by CPU while stall=1.
- addr  input  32  byte address (ALU result).
- wd  input  32  store data.
- rd  output  32  load data; registered.
- stall  output  1  pipeline hold; combinational from state and request.
- valid  output  1  one-cycle pulse marking the response cycle.
- misalign  output  1  response flag: captured addr[1:0] != 0; valid only with valid.

Behaviour:
- Interface decision: one clock (clk); synchronous active-high reset (rst).
- States: IDLE, WAIT, RESP.
- IDLE:
  - If MemRead|MemWrite: capture op, addr, wd into internal registers.
  - Load wait counter with LATENCY-1, go to WAIT.
  - stall=1 in this same cycle.
  - With no request: stall=0.
- WAIT:
  - stall=1.
  - Counter decrements each cycle; at 0, go to RESP.
  - Inputs are ignored; captured values are used.
- RESP:
  - stall=0, valid=1. The pipeline advances at the end of this cycle.
  - Next state is always IDLE.
  - The request is not re-evaluated in RESP, because it still belongs to the finished access.
- Timing: request first seen in IDLE at cycle T gives stall high T..T+LATENCY, RESP at T+LATENCY+1. Total access time is LATENCY+2 cycles.
- Back-to-back: a new request is evaluated in the IDLE cycle after RESP; there is no bubble other than that IDLE cycle.
- Both MemRead and MemWrite high: treated as a store. The read is dropped and rd keeps its previous value.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Store: the array is written at the clock edge entering RESP. rd is unchanged by stores.
- Load: rd is loaded with array[index] at the clock edge entering RESP and holds until the next load response.
- Misaligned access (captured addr[1:0]!=0):
  - No array write.
  - A load returns rd=32'h0.
  - misalign=1 during RESP.
  - Timing is identical to an aligned access.
- Read-after-write: a load following a store to the same word returns the new data.
- Reset (rst=1 at an edge):
  - state=IDLE; rd=0, valid=0, misalign=0; counter=0.
  - stall is forced to 0 while rst=1.
  - Array contents are not reset.
- Reset during WAIT aborts the access and discards the pending store (no array write).
- Request deasserted by a misbehaving CPU during WAIT: the access still completes with the captured values.

Decomposition:
- Shared package, mem_if_pkg:
  - State encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Op encoding (OP_RD, OP_WR).
  - Counter width constant CNT_W=4.
- One natural sub-module, dmem_array: a single-port DEPTH x 32 synchronous array with we, index, wdata, rdata. The FSM, capture registers and counter stay in dmem_responder.

Test Plan:
- Reset, then idle with no request: rd=0, stall=0, valid=0 for 5 cycles.
- LATENCY=2, store addr=0x10 wd=0xDEADBEEF at T=0: stall=1 cycles 0..2; valid=1 at cycle 3; then a load of 0x10 returns rd=0xDEADBEEF with valid in its 4th cycle.
- Back-to-back loads of 0x0 and 0x4 (preloaded 0x11, 0x22): valid at cycles 3 and 7; rd=0x11 then 0x22; stall=0 only at cycles 3 and 7.
- Misaligned load at addr=0x13: stall=1 for 3 cycles, then valid=1, misalign=1, rd=0. A following aligned load of 0x10 shows misalign=0.
- Wrap-around and dual request:
  - Store 0x5 at addr=0x400 (DEPTH=256), then load addr=0x0: rd=0x5.
  - MemRead=MemWrite=1 with wd=0x77 at addr=0x8 completes as a store; a load of 0x8 then returns 0x77.
- Reset asserted mid-WAIT of a store of 0xAA to addr=0x20: state returns to IDLE, stall=0; a subsequent load of 0x20 returns the old contents, not 0xAA.
